// File: rtl/bht_branch_predictor.sv
// Branch history table: ENTRIES saturating CNT_W-bit counters indexed by PC, plus branch/miss stats.
// Optional global-history (gshare) indexing is enabled by defining GSHARE_EN.

module bht_ctr #(
  parameter int CNT_W = 2,
  parameter int INIT  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (we_i) begin
      if (taken_i && cnt_q != MAX)               cnt_d = cnt_q + 1'b1;
      else if (!taken_i && cnt_q != '0)          cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= CNT_W'(INIT);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

module bht_branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int INIT    = 2**CNT_W-1,
  parameter int STAT_W  = 16,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       IF_PC_i,
  output logic              predict_o,
  output logic [IDX_W-1:0]  IF_hist_o,
  input  logic              EX_Branch_i,
  input  logic [31:0]       EX_PC_i,
  input  logic              EX_Predict_i,
  input  logic [IDX_W-1:0]  EX_hist_i,
  input  logic              EX_taken_i,
  input  logic [31:0]       EX_immExtended_i,
  output logic              Predict_wrong_o,
  output logic [31:0]       PC_o,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] miss_cnt_o
);
  logic [IDX_W-1:0]              rd_idx, wr_idx;
  logic [ENTRIES-1:0][CNT_W-1:0] cnt;

`ifdef GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // History shifts only on resolved branches, so it is never speculative.
  always_comb begin
    ghr_d = ghr_q;
    if (EX_Branch_i) ghr_d = (ghr_q << 1) | IDX_W'(EX_taken_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ghr_q <= '0;
    else       ghr_q <= ghr_d;
  end

  assign IF_hist_o = ghr_q;
  assign rd_idx    = IF_PC_i[IDX_W+1:2] ^ ghr_q;
  assign wr_idx    = EX_PC_i[IDX_W+1:2] ^ EX_hist_i;

  logic unused_bits;
  assign unused_bits = ^{IF_PC_i[31:IDX_W+2], IF_PC_i[1:0], EX_PC_i[31:IDX_W+2],
                         EX_PC_i[1:0], EX_immExtended_i[31]};
`else
  assign IF_hist_o = '0;
  assign rd_idx    = IF_PC_i[IDX_W+1:2];
  assign wr_idx    = EX_PC_i[IDX_W+1:2];

  logic unused_bits;
  assign unused_bits = ^{IF_PC_i[31:IDX_W+2], IF_PC_i[1:0], EX_PC_i[31:IDX_W+2],
                         EX_PC_i[1:0], EX_immExtended_i[31], EX_hist_i};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_ent
      bht_ctr #(.CNT_W(CNT_W), .INIT(INIT)) u_ctr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (EX_Branch_i && (wr_idx == IDX_W'(gi))),
        .taken_i (EX_taken_i),
        .cnt_o   (cnt[gi])
      );
    end
  endgenerate

  // Read is the registered value, so a same-cycle update is not bypassed.
  assign predict_o       = cnt[rd_idx][CNT_W-1];
  assign Predict_wrong_o = EX_Branch_i && (EX_Predict_i != EX_taken_i);
  assign PC_o            = EX_Predict_i ? EX_PC_i + 32'd4
                                        : EX_PC_i + {EX_immExtended_i[30:0], 1'b0};

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (EX_Branch_i && branch_cnt_q != STAT_MAX)   branch_cnt_d = branch_cnt_q + 1'b1;
    if (Predict_wrong_o && miss_cnt_q != STAT_MAX) miss_cnt_d   = miss_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;
endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed bench for bht_branch_predictor (16 entries, 2-bit counters, 4-bit stats).
module tb_bht_branch_predictor;
  localparam int IDX_W = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] IF_PC_i;
  logic        predict_o;
  logic [3:0]  IF_hist_o;
  logic        EX_Branch_i;
  logic [31:0] EX_PC_i;
  logic        EX_Predict_i;
  logic [3:0]  EX_hist_i;
  logic        EX_taken_i;
  logic [31:0] EX_immExtended_i;
  logic        Predict_wrong_o;
  logic [31:0] PC_o;
  logic [3:0]  branch_cnt_o;
  logic [3:0]  miss_cnt_o;

  int total = 0;
  int bad   = 0;

  bht_branch_predictor #(.ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut (
    .clk_i, .rst_i, .IF_PC_i, .predict_o, .IF_hist_o, .EX_Branch_i, .EX_PC_i,
    .EX_Predict_i, .EX_hist_i, .EX_taken_i, .EX_immExtended_i, .Predict_wrong_o,
    .PC_o, .branch_cnt_o, .miss_cnt_o
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd(input logic [31:0] pc, input string tag, input logic exp);
    IF_PC_i = pc;
    #1;
    chk(tag, predict_o, exp);
  endtask

  // One resolving branch at the next edge.
  task automatic br(input logic [31:0] pc, input logic pred, input logic tkn);
    EX_Branch_i = 1'b1; EX_PC_i = pc; EX_Predict_i = pred; EX_taken_i = tkn;
    tick();
    EX_Branch_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; IF_PC_i = '0; EX_Branch_i = 1'b0; EX_PC_i = '0; EX_Predict_i = 1'b0;
    EX_hist_i = '0; EX_taken_i = 1'b0; EX_immExtended_i = '0;
    tick();
    rst_i = 1'b0;

    rd(32'h00, "rst_pred_00", 1'b1);
    rd(32'h04, "rst_pred_04", 1'b1);
    rd(32'h3C, "rst_pred_3c", 1'b1);
    chk("rst_branch_cnt", branch_cnt_o, 0);
    chk("rst_miss_cnt", miss_cnt_o, 0);
    chk("rst_hist", IF_hist_o, 0);

`ifdef GSHARE_EN
    // Updates at 0x18 with hist 0110 all land on entry 0: N,N,N,N,T,T,N -> entry0 = 1.
    EX_hist_i = 4'b0110;
    for (int i = 0; i < 4; i++) br(32'h18, 1'b0, 1'b0);
    br(32'h18, 1'b1, 1'b1);
    br(32'h18, 1'b1, 1'b1);
    br(32'h18, 1'b0, 1'b0);
    chk("gs_hist", IF_hist_o, 4'b0110);
    rd(32'h18, "gs_pred_18", 1'b0);
    rd(32'h00, "gs_pred_00", 1'b1);
    chk("gs_branch_cnt", branch_cnt_o, 7);
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("gs_rst_hist", IF_hist_o, 0);
`else
    // Drive entry 2 down to the floor: 3 -> 2 -> 1 -> 0 -> 0.
    rd(32'h08, "sat_pre", 1'b1);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "sat_u1", 1'b1);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "sat_u2", 1'b0);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "sat_u3", 1'b0);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "sat_u4", 1'b0);
    rd(32'h0C, "sat_neighbour", 1'b1);
    // Floor held at 0 (not wrapped to 3): one taken gives 1, a second gives 2.
    br(32'h08, 1'b1, 1'b1); rd(32'h08, "floor_t1", 1'b0);
    br(32'h08, 1'b1, 1'b1); rd(32'h08, "floor_t2", 1'b1);
    chk("sat_branch_cnt", branch_cnt_o, 6);
    chk("sat_miss_cnt", miss_cnt_o, 0);

    // Mispredict correction PC.
    EX_Branch_i = 1'b1; EX_PC_i = 32'h100; EX_immExtended_i = 32'h10;
    EX_Predict_i = 1'b0; EX_taken_i = 1'b1;
    #1;
    chk("mp_nt_wrong", Predict_wrong_o, 1);
    chk("mp_nt_pc", PC_o, 32'h120);
    tick();
    chk("mp_nt_miss", miss_cnt_o, 1);
    EX_Predict_i = 1'b1; EX_taken_i = 1'b0;
    #1;
    chk("mp_t_wrong", Predict_wrong_o, 1);
    chk("mp_t_pc", PC_o, 32'h104);
    tick();
    EX_Branch_i = 1'b0;
    chk("mp_t_miss", miss_cnt_o, 2);
    chk("mp_branch_cnt", branch_cnt_o, 8);
    EX_Predict_i = 1'b0; EX_taken_i = 1'b1;
    #1;
    chk("mp_nobranch", Predict_wrong_o, 0);
    EX_immExtended_i = 32'hFFFF_FFF8;
    #1;
    chk("mp_neg_pc", PC_o, 32'h0F0);

    // 0x48 aliases entry 2 (state 2); not-taken update is not bypassed.
    IF_PC_i = 32'h48;
    EX_Branch_i = 1'b1; EX_PC_i = 32'h08; EX_Predict_i = 1'b1; EX_taken_i = 1'b0;
    #1;
    chk("alias_same_cycle", predict_o, 1);
    tick();
    EX_Branch_i = 1'b0;
    chk("alias_next", predict_o, 0);

    // Hold with no branch.
    tick(); tick();
    rd(32'h48, "hold_pred", 1'b0);
    chk("hold_branch_cnt", branch_cnt_o, 9);

    // Reset wins over a simultaneous not-taken update on entry 2 (state 1).
    rst_i = 1'b1;
    br(32'h08, 1'b0, 1'b0);
    rst_i = 1'b0;
    chk("rmid_branch_cnt", branch_cnt_o, 0);
    chk("rmid_miss_cnt", miss_cnt_o, 0);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "rmid_init_3", 1'b1);
    br(32'h08, 1'b0, 1'b0); rd(32'h08, "rmid_dec_1", 1'b0);

    // Stat counters saturate at 15.
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    for (int i = 0; i < 20; i++) br(32'h200, 1'b0, 1'b1);
    chk("stat_branch_sat", branch_cnt_o, 15);
    chk("stat_miss_sat", miss_cnt_o, 15);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bht_branch_predictor.md
Name: bht_branch_predictor

Overview:
- Parametrised successor to the single-counter dynamic branch predictor.
- Holds a table of ENTRIES saturating counters of CNT_W bits each, indexed by PC bits.
- IF stage reads a prediction combinationally. EX stage resolves the branch, updates the indexed counter, flags mispredicts and supplies the corrected PC.
- Also keeps saturating branch and mispredict statistics counters.

Parameters:
- ENTRIES, 16: number of counter entries; power of two, at least 2. IDX_W = clog2(ENTRIES).
- CNT_W, 2: counter width in bits, 1 to 4.
- INIT, 2**CNT_W-1: reset value of every counter (default is strongly taken).
- STAT_W, 16: width of each statistics counter.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- IF_PC_i  in  32  PC of the instruction in IF.
- predict_o  out  1  prediction for IF_PC_i; 1 = taken.
- IF_hist_o  out  IDX_W  history snapshot, piped to EX; 0 unless GSHARE_EN is defined.
- EX_Branch_i  in  1  a conditional branch is resolving in EX this cycle.
- EX_PC_i  in  32  PC of the EX branch.
- EX_Predict_i  in  1  prediction that was made for the EX branch (piped down).
- EX_hist_i  in  IDX_W  IF_hist_o value piped down with the branch; ignored without GSHARE_EN.
- EX_taken_i  in  1  actual outcome; 1 = taken.
- EX_immExtended_i  in  32  sign-extended branch offset in halfwords.
- Predict_wrong_o  out  1  mispredict flag for the EX branch.
- PC_o  out  32  correct fetch PC when Predict_wrong_o = 1.
- branch_cnt_o  out  STAT_W  number of resolved branches.
- miss_cnt_o  out  STAT_W  number of mispredicts.

Behaviour:
- Indexing:
  - rd_idx = IF_PC_i[IDX_W+1:2].
  - wr_idx = EX_PC_i[IDX_W+1:2].
  - With GSHARE_EN, both indices are additionally XORed with a history value (see Optional Feature).
- Prediction:
  - predict_o = MSB of table[rd_idx], combinational.
  - The read returns the pre-update value even when rd_idx == wr_idx in an update cycle; there is no bypass.
- Mispredict and correction:
  - Predict_wrong_o = EX_Branch_i && (EX_Predict_i != EX_taken_i), combinational.
  - PC_o = EX_Predict_i ? EX_PC_i + 4 : EX_PC_i + (EX_immExtended_i << 1), 32-bit wrap-around.
  - PC_o is don't-care when Predict_wrong_o = 0, but it is always driven by the formula above.
- Counter update, on a rising edge with EX_Branch_i = 1 and rst_i = 0:
  - Taken: table[wr_idx] increments, saturating at 2**CNT_W-1.
  - Not taken: table[wr_idx] decrements, saturating at 0.
  - Only one entry changes per cycle; all other entries hold.
- Hold: with EX_Branch_i = 0, no state changes.
- Statistics:
  - branch_cnt_o increments on each update cycle.
  - miss_cnt_o increments when Predict_wrong_o = 1.
  - Both saturate at 2**STAT_W-1 and never wrap.
- Reset, on a rising edge with rst_i = 1:
  - Every table entry <= INIT; branch_cnt_o, miss_cnt_o and history <= 0.
  - Reset overrides a simultaneous update; an in-flight EX branch is dropped.
  - Combinational outputs follow the reset state from the next cycle.
- Latency: an update written at edge N is visible on predict_o from cycle N+1.
- CNT_W = 1 degenerates to a last-outcome predictor, in which saturation means the counter is simply set or cleared.

Optional Feature:
- Macro: GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (ghr).
  - IF_hist_o = ghr; rd_idx = IF_PC_i[IDX_W+1:2] ^ ghr.
  - wr_idx = EX_PC_i[IDX_W+1:2] ^ EX_hist_i.
  - On each update cycle, ghr <= {ghr[IDX_W-2:0], EX_taken_i}. History is non-speculative; it is updated at EX only.
  - ghr resets to 0.
- Not defined: no ghr, IF_hist_o = 0, EX_hist_i is ignored, and indexing is PC-only.

Test Plan:
- Reset:
  - Stimulus: assert rst_i 1 cycle, default parameters.
  - Response: predict_o = 1 for IF_PC_i = 0x00, 0x04 and 0x3C; both stat counters = 0.
- Saturation:
  - Stimulus: 4 not-taken updates at EX_PC_i = 0x08.
  - Response: entry 2 reads 3, 2, 1, 0, 0 (floor holds); predict_o at 0x08 flips to 0 after the 2nd update.
  - Response: entry at 0x0C is unchanged (=3).
- Mispredict PC:
  - Stimulus: EX_PC_i = 0x100, imm = 0x10, EX_Predict_i = 0, EX_taken_i = 1.
  - Response: Predict_wrong_o = 1, PC_o = 0x120, miss_cnt_o +1.
  - Stimulus: same with EX_Predict_i = 1, taken = 0.
  - Response: PC_o = 0x104.
- Aliasing and same-cycle read/write:
  - Stimulus: IF_PC_i = 0x48 and EX_PC_i = 0x08 (same index, 16 entries), not-taken update from state 2.
  - Response: predict_o = 1 that cycle, 0 the next.
- Reset mid-update:
  - Stimulus: rst_i = 1 in the same cycle as EX_Branch_i = 1.
  - Response: entry = INIT, branch_cnt_o = 0.
- Stat saturation:
  - Stimulus: STAT_W = 4, 20 mispredicting branches.
  - Response: branch_cnt_o = miss_cnt_o = 15.
  - With GSHARE_EN: after taken, taken, not-taken, ghr = 4'b0110 and the IF index equals PC bits XOR 0110.
